// File: rtl/neck_seq_if.sv
// neck_seq_if: start/done handshake bundle between the sequencer and the
// ADC, Kalman filter, differentiators and neck judge.
interface neck_seq_if;
  logic adc_start;
  logic adc_done;
  logic kalman_start;
  logic filter_done;
  logic dif_start;
  logic first_done;
  logic second_done;
  logic third_done;
  logic judge_start;
  logic judge_done;
  logic judge_neck;

  // sequencer side: issues starts, collects dones and the verdict
  modport master (
    output adc_start, kalman_start, dif_start, judge_start,
    input  adc_done, filter_done, first_done, second_done, third_done,
    input  judge_done, judge_neck
  );

  // pipeline side: consumes starts, answers with dones
  modport slave (
    input  adc_start, kalman_start, dif_start, judge_start,
    output adc_done, filter_done, first_done, second_done, third_done,
    output judge_done, judge_neck
  );
endinterface

// File: rtl/neck_seq_ctrl.sv
// neck_seq_ctrl: fixed-rate sequencer for ADC -> Kalman -> differentiators ->
// neck judge, with per-stage timeout supervision, overrun detection and a
// registered necking verdict.
// Optional macro NECK_LOCKOUT_EN: a rising verdict holds necking_out high for
// LOCKOUT cycles, ignoring later verdicts until the hold expires.
module neck_seq_ctrl #(
  parameter int SAMPLE_DIV = 1000,
  parameter int TIMEOUT    = 255,
  parameter int LOCKOUT    = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_run,
  neck_seq_if.master  seq,
  output logic        necking_out,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic [7:0]  err_cnt,
  output logic [15:0] sample_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ADC, S_FILT, S_DIF, S_JUDGE
  } state_t;

  state_t      state_q;
  logic [15:0] tick_q, tick_d;
  logic [7:0]  tmo_q;
  logic [2:0]  mask_q, mask_d;
  logic        tick, stage_done, tmo_fire, ovr_fire, verdict;
  logic [8:0]  err_sum;
  logic [7:0]  err_d;

  assign tick   = en_run && (tick_q == 16'(SAMPLE_DIV - 1));
  assign tick_d = !en_run ? 16'd0 : (tick ? 16'd0 : tick_q + 16'd1);
  assign busy   = state_q inside {S_ADC, S_FILT, S_DIF, S_JUDGE};
  // flags may land together or spread over several cycles
  assign mask_d = mask_q | {seq.third_done, seq.second_done, seq.first_done};

  // awaited done for the current wait state; other states ignore all flags
  always_comb begin
    stage_done = 1'b0;
    unique case (state_q)
      S_ADC:   stage_done = seq.adc_done;
      S_FILT:  stage_done = seq.filter_done;
      S_DIF:   stage_done = &mask_d;
      S_JUDGE: stage_done = seq.judge_done;
      default: stage_done = 1'b0;
    endcase
  end

  // a done arriving in the last allowed cycle still wins over the timeout
  assign tmo_fire = busy && !stage_done && (tmo_q == 8'(TIMEOUT - 1));
  assign ovr_fire = busy && tick;
  assign verdict  = (state_q == S_JUDGE) && seq.judge_done;
  assign err_sum  = {1'b0, err_cnt} + 9'(tmo_fire) + 9'(ovr_fire);
  assign err_d    = err_sum[8] ? 8'hFF : err_sum[7:0];

  // sample-period divider, parked at zero while not running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= '0;
    else        tick_q <= tick_d;
  end

  // sequencing FSM with registered start pulses, error flags and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      tmo_q            <= '0;
      mask_q           <= '0;
      seq.adc_start    <= 1'b0;
      seq.kalman_start <= 1'b0;
      seq.dif_start    <= 1'b0;
      seq.judge_start  <= 1'b0;
      timeout_err      <= 1'b0;
      overrun_err      <= 1'b0;
      err_cnt          <= '0;
      sample_cnt       <= '0;
    end else begin
      seq.adc_start    <= 1'b0;
      seq.kalman_start <= 1'b0;
      seq.dif_start    <= 1'b0;
      seq.judge_start  <= 1'b0;
      timeout_err      <= tmo_fire;
      overrun_err      <= ovr_fire;
      err_cnt          <= err_d;
      tmo_q            <= busy ? tmo_q + 8'd1 : 8'd0;
      mask_q           <= (state_q == S_DIF) ? mask_d : 3'd0;
      unique case (state_q)
        S_IDLE: if (en_run) state_q <= S_WAIT;
        S_WAIT: begin
          if (!en_run) state_q <= S_IDLE;
          else if (tick) begin
            state_q       <= S_ADC;
            seq.adc_start <= 1'b1;
          end
        end
        S_ADC: if (seq.adc_done) begin
          state_q          <= S_FILT;
          seq.kalman_start <= 1'b1;
          tmo_q            <= '0;
        end
        S_FILT: if (seq.filter_done) begin
          state_q       <= S_DIF;
          seq.dif_start <= 1'b1;
          tmo_q         <= '0;
        end
        S_DIF: if (&mask_d) begin
          state_q         <= S_JUDGE;
          seq.judge_start <= 1'b1;
          tmo_q           <= '0;
          mask_q          <= '0;
        end
        S_JUDGE: if (seq.judge_done) begin
          state_q    <= en_run ? S_WAIT : S_IDLE;
          sample_cnt <= sample_cnt + 16'd1;
          tmo_q      <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
      // abandon the sequence; a run-enable drop parks the FSM in IDLE
      if (tmo_fire) begin
        state_q <= en_run ? S_WAIT : S_IDLE;
        tmo_q   <= '0;
        mask_q  <= '0;
      end
    end
  end

`ifdef NECK_LOCKOUT_EN
  localparam int HOLD_W = $clog2(LOCKOUT + 1);
  logic [HOLD_W-1:0] hold_q;

  // verdict register; a 0->1 verdict opens a hold window that masks verdicts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      necking_out <= 1'b0;
      hold_q      <= '0;
    end else begin
      if (hold_q != '0) hold_q <= hold_q - HOLD_W'(1);
      if (verdict && hold_q == '0) begin
        necking_out <= seq.judge_neck;
        if (seq.judge_neck && !necking_out) hold_q <= HOLD_W'(LOCKOUT);
      end
    end
  end
`else
  logic unused_lockout;
  assign unused_lockout = (LOCKOUT == 0);

  // verdict register: follows every judge verdict, persists otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       necking_out <= 1'b0;
    else if (verdict) necking_out <= seq.judge_neck;
  end
`endif

endmodule

// File: tb/tb_neck_seq_ctrl.sv
// tb_neck_seq_ctrl: directed scenarios with delayed-done responders, a
// sequence-level reference model checked every cycle, and literal checks.
module tb_neck_seq_ctrl;
  localparam int SD = 20, TO = 8, LK = 100;
`ifdef NECK_LOCKOUT_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, en_run = 1'b0;
  logic        necking_out, busy, timeout_err, overrun_err;
  logic [7:0]  err_cnt;
  logic [15:0] sample_cnt;

  neck_seq_if bus();

  neck_seq_ctrl #(.SAMPLE_DIV(SD), .TIMEOUT(TO), .LOCKOUT(LK)) dut (
    .clk(clk), .rst_n(rst_n), .en_run(en_run), .seq(bus),
    .necking_out(necking_out), .busy(busy), .timeout_err(timeout_err),
    .overrun_err(overrun_err), .err_cnt(err_cnt), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc_n = 0;
  int lat_adc = 3, lat_filt = 3, lat_first = 3, lat_second = 3, lat_third = 3, lat_judge = 3;
  int cd_adc, cd_filt, cd_1, cd_2, cd_3, cd_j;
  bit verdict;
  int t_ev[6];

  // reference model: phase 0 idle, 1 waiting for tick, 2 running stage m_stage
  int m_phase, m_stage, m_wait, m_tick, m_mask, m_hold, m_err, m_cnt;
  bit m_neck, e_tmo, e_ovr;
  bit [3:0] e_start;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_stage = 0; m_wait = 0; m_tick = 0; m_mask = 0;
    m_hold = 0; m_err = 0; m_cnt = 0; m_neck = 0;
    e_start = '0; e_tmo = 0; e_ovr = 0;
  endtask

  task automatic model_verdict(input bit nk, input int hold_prev);
    if (!LOCK_ON) m_neck = nk;
    else if (hold_prev == 0) begin
      if (nk && !m_neck) m_hold = LK;
      m_neck = nk;
    end
  endtask

  task automatic model_step();
    bit tick, done;
    int inc, hold_prev;
    done = 0; inc = 0;
    tick = en_run && (m_tick == SD - 1);
    m_tick = en_run ? (m_tick + 1) % SD : 0;
    e_start = '0; e_tmo = 0; e_ovr = 0;
    hold_prev = m_hold;
    if (m_hold > 0) m_hold--;
    if (m_phase == 2 && tick) begin e_ovr = 1; inc++; end
    case (m_phase)
      0: if (en_run) m_phase = 1;
      1: if (!en_run) m_phase = 0;
         else if (tick) begin m_phase = 2; m_stage = 0; m_wait = 0; e_start[0] = 1; end
      default: begin
        m_wait++;
        case (m_stage)
          0: done = bus.adc_done;
          1: done = bus.filter_done;
          2: begin
            m_mask = m_mask | int'({bus.third_done, bus.second_done, bus.first_done});
            done = (m_mask == 7);
          end
          default: done = bus.judge_done;
        endcase
        if (done) begin
          m_mask = 0;
          if (m_stage == 3) begin
            model_verdict(bus.judge_neck, hold_prev);
            m_cnt = (m_cnt + 1) % 65536;
            m_phase = en_run ? 1 : 0;
          end else begin
            m_stage++; m_wait = 0; e_start[m_stage] = 1;
          end
        end else if (m_wait == TO) begin
          e_tmo = 1; inc++; m_mask = 0; m_phase = en_run ? 1 : 0;
        end
      end
    endcase
    m_err = (m_err + inc > 255) ? 255 : m_err + inc;
  endtask

  function automatic bit ev(input int i);
    case (i)
      0: return bus.adc_start;
      1: return bus.kalman_start;
      2: return bus.dif_start;
      3: return bus.judge_start;
      4: return timeout_err;
      default: return overrun_err;
    endcase
  endfunction

  task automatic resp(input logic st, input int lat, inout int cd, output logic d);
    d = 1'b0;
    if (cd > 0) begin cd--; if (cd == 0) d = 1'b1; end
    if (st && lat > 0) cd = lat;
  endtask

  task automatic clear_resp();
    cd_adc = 0; cd_filt = 0; cd_1 = 0; cd_2 = 0; cd_3 = 0; cd_j = 0;
    bus.adc_done = 0; bus.filter_done = 0; bus.first_done = 0;
    bus.second_done = 0; bus.third_done = 0; bus.judge_done = 0; bus.judge_neck = 0;
  endtask

  // one clock: model advances on the edge, outputs compared on the falling edge
  task automatic cyc();
    logic d;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    cyc_n++;
    chk("pulses", int'({bus.adc_start, bus.kalman_start, bus.dif_start, bus.judge_start,
                        timeout_err, overrun_err, busy, necking_out}),
                  int'({e_start[0], e_start[1], e_start[2], e_start[3],
                        e_tmo, e_ovr, m_phase == 2, m_neck}));
    chk("err_cnt", int'(err_cnt), m_err);
    chk("sample_cnt", int'(sample_cnt), m_cnt);
    for (int i = 0; i < 6; i++) if (ev(i)) t_ev[i] = cyc_n;
    if (!rst_n) clear_resp();
    else begin
      resp(bus.adc_start, lat_adc, cd_adc, d);      bus.adc_done = d;
      resp(bus.kalman_start, lat_filt, cd_filt, d); bus.filter_done = d;
      resp(bus.dif_start, lat_first, cd_1, d);      bus.first_done = d;
      resp(bus.dif_start, lat_second, cd_2, d);     bus.second_done = d;
      resp(bus.dif_start, lat_third, cd_3, d);      bus.third_done = d;
      resp(bus.judge_start, lat_judge, cd_j, d);    bus.judge_done = d;
      bus.judge_neck = d ? verdict : 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_ev(input int i, input int max, input string nm);
    int k = 0;
    do begin cyc(); k++; end while (!ev(i) && k < max);
    n_tests++;
    if (!ev(i)) begin
      n_fail++;
      $display("FAIL wait_%s: no pulse within %0d cycles", nm, max);
    end
  endtask

  task automatic set_lat(input int v);
    lat_adc = v; lat_filt = v; lat_first = v; lat_second = v; lat_third = v; lat_judge = v;
  endtask

  task automatic do_reset();
    en_run = 0; rst_n = 0; verdict = 0; clear_resp();
    run(2);
    rst_n = 1;
    chk("reset_outs", int'({bus.adc_start, bus.kalman_start, bus.dif_start, bus.judge_start,
                            necking_out, busy, timeout_err, overrun_err}), 0);
    chk("reset_cnts", int'({err_cnt, sample_cnt}), 0);
  endtask

  initial begin
    int s0, n_ovr, n_adc;
    clear_resp();
    model_reset();

    // 1: steady run, every stage answers after 3 cycles
    do_reset();
    set_lat(3); en_run = 1;
    wait_ev(0, 60, "adc");
    s0 = t_ev[0];
    wait_ev(1, 10, "kal"); chk("adc_to_kal", t_ev[1] - s0, 4);
    wait_ev(2, 10, "dif"); chk("kal_to_dif", t_ev[2] - t_ev[1], 4);
    wait_ev(3, 10, "jdg"); chk("dif_to_jdg", t_ev[3] - t_ev[2], 4);
    for (int i = 1; i < 5; i++) begin
      s0 = t_ev[0];
      wait_ev(0, 25, "adc");
      chk("adc_period", t_ev[0] - s0, 20);
    end
    run(16);
    chk("sample_cnt_5", int'(sample_cnt), 5);
    chk("err_none", int'(err_cnt), 0);

    // 2: third_done 4 cycles after first/second; mask must clear between sequences
    do_reset();
    set_lat(3); lat_third = 7; en_run = 1;
    for (int i = 0; i < 2; i++) begin
      wait_ev(2, 60, "dif");
      wait_ev(3, 15, "jdg");
      chk("dif_to_jdg_late3", t_ev[3] - t_ev[2], 8);
    end
    run(20);

    // 3: filter never answers -> timeout 8 cycles after FILT entry
    do_reset();
    set_lat(3); lat_filt = -1; en_run = 1;
    wait_ev(0, 60, "adc"); s0 = t_ev[0];
    wait_ev(1, 10, "kal");
    wait_ev(4, 20, "tmo");
    chk("kal_to_tmo", t_ev[4] - t_ev[1], 8);
    chk("err_after_tmo", int'(err_cnt), 1);
    chk("sample_after_tmo", int'(sample_cnt), 0);
    wait_ev(0, 25, "adc_again");
    chk("adc_after_tmo", t_ev[0] - s0, 20);
    run(10);

    // 4: slow stages overrun the period once, sequence still completes
    do_reset();
    set_lat(6); en_run = 1;
    wait_ev(0, 60, "adc"); s0 = t_ev[0];
    n_ovr = 0;
    repeat (28) begin cyc(); if (overrun_err) n_ovr++; end
    chk("ovr_count", n_ovr, 1);
    chk("ovr_time", t_ev[5] - s0, 20);
    chk("err_after_ovr", int'(err_cnt), 1);
    chk("sample_after_ovr", int'(sample_cnt), 1);
    set_lat(3);
    run(40);

    // 5: verdict 1 then 0 on following sequences
    do_reset();
    set_lat(3); verdict = 1; en_run = 1;
    wait_ev(3, 60, "jdg");
    run(4);
    chk("neck_set", int'(necking_out), 1);
    verdict = 0;
    run(20);
    chk("neck_after_v2", int'(necking_out), LOCK_ON ? 1 : 0);
    run(79);
    chk("neck_at_hold_end", int'(necking_out), LOCK_ON ? 1 : 0);
    run(27);
    chk("neck_released", int'(necking_out), 0);

    // 6: asynchronous reset in the middle of DIF
    do_reset();
    set_lat(3); en_run = 1;
    wait_ev(2, 60, "dif");
    wait_ev(2, 25, "dif2");
    cyc();
    #2 rst_n = 0;
    #1;
    chk("async_rst_outs", int'({bus.adc_start, bus.kalman_start, bus.dif_start, bus.judge_start,
                                necking_out, busy, timeout_err, overrun_err}), 0);
    chk("async_rst_cnts", int'({err_cnt, sample_cnt}), 0);
    clear_resp();
    run(2);
    rst_n = 1;
    run(30);
    chk("sample_after_rst", int'(sample_cnt), 0);

    // 7: run enable drops mid-sequence -> finish, then park in IDLE
    do_reset();
    set_lat(3); en_run = 1;
    wait_ev(0, 60, "adc");
    en_run = 0;
    n_adc = 0;
    repeat (40) begin cyc(); if (bus.adc_start) n_adc++; end
    chk("no_adc_after_stop", n_adc, 0);
    chk("sample_after_stop", int'(sample_cnt), 1);

    // 8: ADC never answers -> error counter saturates
    do_reset();
    set_lat(3); lat_adc = -1; en_run = 1;
    run(5200);
    chk("err_saturated", int'(err_cnt), 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/neck_seq_ctrl.md
Name: neck_seq_ctrl

Overview:
Sequencer for the neck-detection pipeline: ADC sample -> Kalman filter -> 1st/2nd/3rd-order differentiators -> neck judge. Runs off the 100 MHz system clock and issues one start pulse per stage at a fixed sample rate. Collects each stage's done flag and supervises every stage with a timeout. Registers the judge verdict as the system necking output and counts sequencing faults.

Parameters:
SAMPLE_DIV, 1000, clock cycles per sample period (100 kS/s at 100 MHz); legal range 16..65535
TIMEOUT, 255, maximum cycles to wait for any stage done flag; legal range 1..255
LOCKOUT, 50000, necking hold/suppress cycles (used only with NECK_LOCKOUT_EN)

Ports:
clk  in  1  system clock (100 MHz PLL output)
rst_n  in  1  asynchronous active-low reset
en_run  in  1  run enable (level)
adc_start  out  1  one-cycle ADC conversion request
adc_done  in  1  ADC conversion-complete pulse
kalman_start  out  1  one-cycle filter enable
filter_done  in  1  filter-complete pulse
dif_start  out  1  one-cycle enable shared by all three differentiators
first_done  in  1  1st-order differentiator complete
second_done  in  1  2nd-order differentiator complete
third_done  in  1  3rd-order differentiator complete
judge_start  out  1  one-cycle judge enable
judge_done  in  1  judge-complete pulse
judge_neck  in  1  judge verdict, valid in the judge_done cycle
necking_out  out  1  registered necking signal
busy  out  1  high in any state other than IDLE and WAIT_TICK
timeout_err  out  1  one-cycle pulse on a stage timeout
overrun_err  out  1  one-cycle pulse on a tick dropped because busy
err_cnt  out  8  saturating count of timeouts plus overruns
sample_cnt  out  16  wrapping count of completed sequences

Behaviour:
- Interface fixed: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset: all outputs 0; state IDLE; tick counter, timeout counter and done mask cleared.
- Tick counter:
  - Held at 0 while en_run=0.
  - Otherwise counts 0..SAMPLE_DIV-1 and wraps; tick is asserted when count = SAMPLE_DIV-1.
- States: IDLE, WAIT_TICK, ADC, FILT, DIF, JUDGE. All start pulses are registered and last exactly one cycle.
- IDLE -> WAIT_TICK when en_run=1.
- WAIT_TICK -> ADC on tick. adc_start is high in the first ADC cycle, which is tick cycle + 1.
- ADC -> FILT on adc_done; kalman_start pulses on FILT entry.
- FILT -> DIF on filter_done; dif_start pulses on DIF entry.
- DIF done handling:
  - A 3-bit mask records first_done, second_done and third_done. Flags may arrive in the same cycle or in different cycles.
  - When the mask is full -> JUDGE. judge_start pulses on entry; the mask clears.
- JUDGE -> WAIT_TICK on judge_done:
  - necking_out <= judge_neck, updated the cycle after judge_done.
  - sample_cnt increments by 1 (wraps 65535 -> 0).
- Done flags are sampled only in their own wait state; flags arriving in any other state are ignored.
- Timeout:
  - Counter clears on every state entry and increments each cycle spent in ADC, FILT, DIF or JUDGE.
  - On reaching TIMEOUT without the awaited done: timeout_err pulses, err_cnt increments (saturates at 255), next state WAIT_TICK.
  - necking_out and sample_cnt are unchanged by a timeout.
- Overrun: a tick while busy=1 is dropped; overrun_err pulses and err_cnt increments. A timeout and an overrun in the same cycle increment err_cnt by 2, saturating.
- en_run falling mid-sequence: the current sequence completes or times out, then the FSM enters IDLE rather than WAIT_TICK. In WAIT_TICK, en_run=0 -> IDLE on the next cycle.
- necking_out persists through IDLE; only reset or a new verdict changes it.

Optional Feature:
NECK_LOCKOUT_EN
- Defined:
  - A 0->1 verdict sets necking_out=1 and starts a LOCKOUT-cycle hold counter.
  - While the counter is nonzero, necking_out stays 1 regardless of later verdicts.
  - After expiry, necking_out follows the next judge verdict.
- Undefined: necking_out follows every verdict directly and the hold logic is absent.

Test Plan:
- SAMPLE_DIV=20, en_run=1, all stages answer done 3 cycles after their start -> adc_start pulses every 20 cycles; kalman_start, dif_start and judge_start follow in order; sample_cnt = 5 after 5 periods.
- third_done 4 cycles after first_done, second_done together with first_done -> judge_start only in the cycle after third_done; mask cleared afterwards.
- filter_done never asserted, TIMEOUT=8 -> timeout_err pulses 8 cycles after FILT entry; err_cnt=1; next tick starts a new ADC cycle.
- Judge answers 25 cycles after its start with SAMPLE_DIV=20 -> overrun_err pulses once; err_cnt=1; the sequence still completes.
- judge_neck=1 then 0 on consecutive sequences, LOCKOUT=100, macro defined -> necking_out stays 1 for 100 cycles. Same stimulus with macro undefined -> necking_out drops after the second verdict.
- rst_n low mid-DIF -> all outputs 0 immediately; after release the FSM starts from IDLE and sample_cnt = 0.
